// File: rtl/fsm_arbiter_pkg.sv
// Shared types and helpers for the N-channel request/grant arbiter.
//   state_t    : FSM encoding (IDLE / GRANT); encodings outside the enum recover to IDLE
//   MODE_*     : arbitration policy selectors for the MODE parameter
//   oh2idx()   : one-hot (up to MAX_REQ bits) to binary index
package fsm_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    GRANT = 2'b10
  } state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
  localparam int MAX_REQ    = 32;

  // OR-reduction of the set bit positions; exact for a one-hot or zero input.
  function automatic logic [4:0] oh2idx(input logic [MAX_REQ-1:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++)
      if (oh[i]) idx = idx | 5'(i);
    return idx;
  endfunction

endpackage

// File: rtl/fsm_arbiter_n_arb_pick.sv
// Combinational rotated priority encoder.
//   i_elig  : eligible request vector
//   i_start : first index searched in round-robin mode (ignored in fixed mode)
//   i_mode  : 0 = fixed (search from 0), 1 = rotate from i_start with wrap
//   o_valid : some channel is eligible
//   o_idx   : winning channel index
module arb_pick
  import fsm_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [IDW-1:0]     i_start,
  input  logic               i_mode,
  output logic               o_valid,
  output logic [IDW-1:0]     o_idx
);

  always_comb begin
    int base;
    int c;
    o_valid = 1'b0;
    o_idx   = '0;
    base    = i_mode ? int'(i_start) : 0;
    c       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // base + k < 2*NUM_REQ, so a single conditional subtract wraps it
      c = base + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!o_valid && i_elig[c]) begin
        o_valid = 1'b1;
        o_idx   = IDW'(c);
      end
    end
  end

endmodule

// File: rtl/fsm_arbiter_n.sv
// N-channel request/grant arbiter with fixed or round-robin policy and an
// optional maximum-hold timeout that locks the revoked channel out until it
// drops its request.
//   clock, reset : rising-edge clock, async active-high reset
//   req          : level request per channel
//   gnt          : registered one-hot grant (or zero)
//   gnt_id       : index of granted channel, valid while busy
//   busy         : any grant active
//   timeout      : one-cycle pulse on the first cycle after a forced revoke
module fsm_arbiter_n
  import fsm_arbiter_pkg::*;
#(
  parameter int  NUM_REQ  = 4,
  parameter int  MODE     = MODE_FIXED,
  parameter int  MAX_HOLD = 0,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               busy,
  output logic               timeout
);

  localparam int             CW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0]  HOLD_MAX = CW'(MAX_HOLD);

  state_t             r_state;
  logic [NUM_REQ-1:0] r_lock;
  logic [IDW-1:0]     r_ptr;
  logic [CW-1:0]      r_hold;

  logic [NUM_REQ-1:0] w_elig;
  logic [IDW-1:0]     w_start;
  logic [IDW-1:0]     w_win;
  logic [IDW-1:0]     w_owner;
  logic               w_valid;
  logic               w_limit;
  logic               w_release;
  logic               w_revoke;

  assign w_elig    = req & ~r_lock;
  assign w_start   = (r_ptr == IDW'(NUM_REQ - 1)) ? '0 : r_ptr + IDW'(1);
  assign w_owner   = IDW'(oh2idx(MAX_REQ'(gnt)));
  assign w_limit   = (MAX_HOLD > 0) && (r_hold == HOLD_MAX);
  assign w_release = (r_state == GRANT) && !req[w_owner];
  // A release on the limit cycle wins over the timeout.
  assign w_revoke  = (r_state == GRANT) && req[w_owner] && w_limit;

  arb_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
    .i_elig  (w_elig),
    .i_start (w_start),
    .i_mode  (MODE == MODE_RR),
    .o_valid (w_valid),
    .o_idx   (w_win)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      r_lock  <= '0;
      r_ptr   <= IDW'(NUM_REQ - 1);
      r_hold  <= '0;
    end else begin
      timeout <= 1'b0;
      // Lockout drops whenever the channel releases its request; a revoke
      // locks the current owner (gnt is its one-hot).
      r_lock  <= (r_lock & req) | (w_revoke ? gnt : '0);
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state <= GRANT;
            gnt     <= NUM_REQ'(1) << w_win;
            gnt_id  <= w_win;
            busy    <= 1'b1;
            r_ptr   <= w_win;
            r_hold  <= (MAX_HOLD > 0) ? CW'(1) : '0;
          end
        end
        GRANT: begin
          if (w_release || w_revoke) begin
            r_state <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            r_hold  <= '0;
            timeout <= w_revoke;
          end else if (MAX_HOLD > 0 && r_hold != HOLD_MAX) begin
            r_hold  <= r_hold + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          gnt     <= '0;
          gnt_id  <= '0;
          busy    <= 1'b0;
          r_hold  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_arbiter_n.sv
// Bench for fsm_arbiter_n: four instances (fixed, round-robin, fixed with
// MAX_HOLD=3, 7-channel round-robin) checked against directed expectations
// and a cycle-level behavioural model.
module tb_fsm_arbiter_n;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req0, req1, req2;
  logic [6:0] req3;
  logic [3:0] gnt0, gnt1, gnt2;
  logic [6:0] gnt3;
  logic [1:0] id0, id1, id2;
  logic [2:0] id3;
  logic       busy0, busy1, busy2, busy3;
  logic       to0, to1, to2, to3;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fsm_arbiter_n #(.NUM_REQ(4), .MODE(0), .MAX_HOLD(0)) u_fix (
    .clock(clock), .reset(reset), .req(req0), .gnt(gnt0), .gnt_id(id0), .busy(busy0), .timeout(to0));
  fsm_arbiter_n #(.NUM_REQ(4), .MODE(1), .MAX_HOLD(0)) u_rr (
    .clock(clock), .reset(reset), .req(req1), .gnt(gnt1), .gnt_id(id1), .busy(busy1), .timeout(to1));
  fsm_arbiter_n #(.NUM_REQ(4), .MODE(0), .MAX_HOLD(3)) u_to (
    .clock(clock), .reset(reset), .req(req2), .gnt(gnt2), .gnt_id(id2), .busy(busy2), .timeout(to2));
  fsm_arbiter_n #(.NUM_REQ(7), .MODE(1), .MAX_HOLD(0)) u_rr7 (
    .clock(clock), .reset(reset), .req(req3), .gnt(gnt3), .gnt_id(id3), .busy(busy3), .timeout(to3));

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int       own;   // -1 when nobody holds the resource
    int       hold;  // grant cycles so far
    int       ptr;   // last round-robin winner
    bit [31:0] lock;
    bit       to;
  } m_t;

  localparam int P_N   [4] = '{4, 4, 4, 7};
  localparam int P_MODE[4] = '{0, 1, 0, 1};
  localparam int P_MH  [4] = '{0, 0, 3, 0};

  m_t          m_st [4];
  logic [31:0] a_req [4];
  logic [31:0] a_gnt [4];
  int          a_id  [4];
  logic        a_busy[4];
  logic        a_to  [4];

  always_comb begin
    a_req[0] = 32'(req0);  a_req[1] = 32'(req1);  a_req[2] = 32'(req2);  a_req[3] = 32'(req3);
    a_gnt[0] = 32'(gnt0);  a_gnt[1] = 32'(gnt1);  a_gnt[2] = 32'(gnt2);  a_gnt[3] = 32'(gnt3);
    a_id[0]  = int'(id0);  a_id[1]  = int'(id1);  a_id[2]  = int'(id2);  a_id[3]  = int'(id3);
    a_busy[0] = busy0; a_busy[1] = busy1; a_busy[2] = busy2; a_busy[3] = busy3;
    a_to[0]   = to0;   a_to[1]   = to1;   a_to[2]   = to2;   a_to[3]   = to3;
  end

  function automatic m_t m_step(m_t s, int n, int mode, int mh, bit [31:0] rq);
    m_t r = s;
    r.to = 1'b0;
    if (s.own < 0) begin
      for (int k = 0; k < n; k++) begin
        int c = mode ? (s.ptr + 1 + k) % n : k;
        if (r.own < 0 && rq[c] && !s.lock[c]) begin
          r.own = c; r.ptr = c; r.hold = 1;
        end
      end
    end else if (!rq[s.own]) begin
      r.own = -1;
    end else if (mh > 0 && s.hold >= mh) begin
      r.lock[s.own] = 1'b1; r.to = 1'b1; r.own = -1;
    end else begin
      r.hold = s.hold + 1;
    end
    r.lock = r.lock & rq;
    return r;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int u = 0; u < 4; u++)
        m_st[u] <= m_t'{own: -1, hold: 0, ptr: P_N[u] - 1, lock: '0, to: 1'b0};
    end else begin
      for (int u = 0; u < 4; u++)
        m_st[u] <= m_step(m_st[u], P_N[u], P_MODE[u], P_MH[u], a_req[u]);
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    req0 = '0; req1 = '0; req2 = '0; req3 = '0;
    repeat (3) @(negedge clock);
    for (int u = 0; u < 4; u++) begin
      checks++;
      if (a_gnt[u] !== 32'd0 || a_busy[u] !== 1'b0 || a_to[u] !== 1'b0 || a_id[u] != 0) begin
        errors++;
        $display("FAIL reset_state u%0d: gnt=%h busy=%b to=%b id=%0d want all zero",
                 u, a_gnt[u], a_busy[u], a_to[u], a_id[u]);
      end
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_fixed();
    req0 = 4'b1010;
    @(negedge clock);
    checks++;
    if (gnt0 !== 4'b0010 || id0 !== 2'd1 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL fixed_grant: gnt=%b id=%0d busy=%b want gnt=0010 id=1 busy=1", gnt0, id0, busy0);
    end
    req0 = 4'b1000;
    @(negedge clock);
    checks++;
    if (gnt0 !== 4'b0000 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL fixed_gap: gnt=%b busy=%b want gnt=0000 busy=0", gnt0, busy0);
    end
    @(negedge clock);
    checks++;
    if (gnt0 !== 4'b1000 || id0 !== 2'd3 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL fixed_next: gnt=%b id=%0d want gnt=1000 id=3", gnt0, id0);
    end
    req0 = '0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_rr();
    int order[$];
    int held = 0;
    req1 = 4'hF;
    for (int cyc = 0; cyc < 30 && order.size() < 5; cyc++) begin
      @(negedge clock);
      checks++;
      if (a_gnt[1] !== ((m_st[1].own >= 0) ? (32'd1 << m_st[1].own) : 32'd0) ||
          a_busy[1] !== (m_st[1].own >= 0) || a_to[1] !== m_st[1].to ||
          (a_busy[1] && a_id[1] != m_st[1].own)) begin
        errors++;
        $display("FAIL rr_model cyc%0d: gnt=%b id=%0d want owner=%0d", cyc, gnt1, id1, m_st[1].own);
      end
      req1 = 4'hF;
      if (busy1) begin
        held++;
        if (held == 2) begin
          order.push_back(int'(id1));
          req1[id1] = 1'b0;
          held = 0;
        end
      end
    end
    checks++;
    if (order.size() != 5) begin
      errors++;
      $display("FAIL rr_count: grants=%0d want 5", order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      checks++;
      if (order[i] != i % 4) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], i % 4);
      end
    end
    req1 = '0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_timeout();
    bit [3:0] drv [13] = '{4'b0100, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0100,
                           4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    bit [3:0] eg  [13] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0001,
                           4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
    bit       et  [13] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int k = 0; k < 13; k++) begin
      checks++;
      if (gnt2 !== eg[k] || to2 !== et[k] || busy2 !== (eg[k] != 0)) begin
        errors++;
        $display("FAIL timeout_step%0d: gnt=%b to=%b busy=%b want gnt=%b to=%b", k, gnt2, to2, busy2, eg[k], et[k]);
      end
      req2 = drv[k];
      @(negedge clock);
    end
  endtask

  task automatic test_hold_release();
    bit [3:0] drv [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    bit [3:0] eg  [7] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000};
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (gnt2 !== eg[k] || to2 !== 1'b0) begin
        errors++;
        $display("FAIL hold_release_step%0d: gnt=%b to=%b want gnt=%b to=0", k, gnt2, to2, eg[k]);
      end
      req2 = drv[k];
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid();
    req1 = 4'b0100;
    @(negedge clock);
    checks++;
    if (gnt1 !== 4'b0100) begin
      errors++;
      $display("FAIL rst_pre: gnt=%b want 0100", gnt1);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (gnt1 !== 4'b0000 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: gnt=%b busy=%b want 0000/0", gnt1, busy1);
    end
    @(negedge clock);
    reset = 1'b0;
    req1  = 4'hF;
    @(negedge clock);
    checks++;
    if (gnt1 !== 4'b0001 || id1 !== 2'd0) begin
      errors++;
      $display("FAIL rst_restart: gnt=%b id=%0d want 0001 id=0", gnt1, id1);
    end
    req1 = '0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_wrap7();
    int order[$];
    req3 = 7'h7F;
    for (int cyc = 0; cyc < 40 && order.size() < 8; cyc++) begin
      @(negedge clock);
      checks++;
      if (a_gnt[3] !== ((m_st[3].own >= 0) ? (32'd1 << m_st[3].own) : 32'd0) ||
          a_busy[3] !== (m_st[3].own >= 0) || (a_busy[3] && a_id[3] != m_st[3].own)) begin
        errors++;
        $display("FAIL wrap7_model cyc%0d: gnt=%b id=%0d want owner=%0d", cyc, gnt3, id3, m_st[3].own);
      end
      req3 = 7'h7F;
      if (busy3) begin
        order.push_back(int'(id3));
        req3[id3] = 1'b0;
      end
    end
    checks++;
    if (order.size() != 8) begin
      errors++;
      $display("FAIL wrap7_count: grants=%0d want 8", order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      checks++;
      if (order[i] != i % 7) begin
        errors++;
        $display("FAIL wrap7_order[%0d]: got %0d want %0d", i, order[i], i % 7);
      end
    end
    req3 = '0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clock);
      for (int u = 0; u < 4; u++) begin
        checks++;
        if (a_gnt[u] !== ((m_st[u].own >= 0) ? (32'd1 << m_st[u].own) : 32'd0) ||
            a_busy[u] !== (m_st[u].own >= 0) || a_to[u] !== m_st[u].to ||
            (a_busy[u] && a_id[u] != m_st[u].own)) begin
          errors++;
          $display("FAIL random u%0d cyc%0d: gnt=%h id=%0d busy=%b to=%b want owner=%0d to=%b",
                   u, cyc, a_gnt[u], a_id[u], a_busy[u], a_to[u], m_st[u].own, m_st[u].to);
        end
      end
      // each request bit toggles with probability 1/8 per cycle
      req0 ^= 4'($urandom & $urandom & $urandom);
      req1 ^= 4'($urandom & $urandom & $urandom);
      req2 ^= 4'($urandom & $urandom & $urandom);
      req3 ^= 7'($urandom & $urandom & $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr();
    test_timeout();
    test_hold_release();
    test_reset_mid();
    test_wrap7();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
